branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Upstream neighbour of the branch-correction counter stage.
- Holds the fetch unit's in-flight branch predictions in a small in-order queue.
- When execute reports each branch outcome, compares it with the oldest prediction.
- Emits a one-cycle `o_fire` strobe with a 33-bit `{mispredict, correct_pc}` word for the correction stage; flushes younger predictions on a mispredict.

Parameters:
- DEPTH, 4, number of prediction queue entries (power of two, ≥2).
- PC_W, 32, PC width. `o_data` is PC_W+1 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-low
- pred_valid  input  1  fetch presents a prediction
- pred_ready  output  1  queue can accept; equals !full
- pred_pc  input  PC_W  PC of predicted branch
- pred_taken  input  1  predicted direction
- pred_target  input  PC_W  predicted target (ignored when not taken)
- res_valid  input  1  execute resolves the oldest outstanding branch
- res_taken  input  1  actual direction
- res_target  input  PC_W  actual target
- o_fire  output  1  one-cycle strobe: `o_data` valid
- o_data  output  PC_W+1  {mispredict, correct_pc}
- o_flush  output  1  one-cycle pulse, coincident with a mispredict `o_fire`
- o_underflow  output  1  one-cycle pulse: `res_valid` with empty queue
- o_count  output  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (rst=0, async): queue empty, read/write pointers 0, `o_count`=0, `o_fire`=0, `o_data`=0, `o_flush`=0, `o_underflow`=0. `pred_ready`=1 once rst=1.
- Queue storage: circular buffer of {pc, taken, target}. Pointers wrap modulo DEPTH. Full/empty are tracked by `o_count`.
- Push: a prediction is written when pred_valid && pred_ready at a clock edge.
- Pop/compare: when res_valid && !empty at an edge, the head entry is compared and popped.
  - mispredict = (res_taken != head.taken) || (res_taken && res_target != head.target).
  - correct_pc = res_taken ? res_target : head.pc + 4, with +4 truncated to PC_W (wraps).
  - Next cycle: `o_fire`=1 and `o_data`={mispredict, correct_pc}. Latency is exactly 1 cycle.
  - `o_data` holds its value until the next `o_fire`.
  - `o_fire` is 0 in every cycle not following a resolve.
- Mispredict flush: in the same edge as the pop, the whole queue is cleared (count=0, rd=wr). A push in that same cycle is discarded. `o_flush`=1 alongside `o_fire`.
- Correct prediction: `o_fire`=1 with `o_data[PC_W]`=0. No flush.
- Simultaneous push and pop (no mispredict): both occur and count is unchanged. This is legal when full because `pred_ready` is computed from the pre-edge count, so no push is accepted while full.
- Underflow: res_valid with empty queue produces no `o_fire` and no state change. `o_underflow` pulses the next cycle.
- Reset mid-operation: all entries are dropped immediately and outputs return to reset values asynchronously. A pending `o_fire` is lost.
- No combinational path from res_* to any output. `pred_ready` depends only on registered count.

Test Plan:
1. Reset, then push pc=0x100 taken target=0x200; resolve taken 0x200 -> next cycle `o_fire`=1, `o_data`={0,0x200}, `o_flush`=0, `o_count`=0.
2. Push pc=0x100 not-taken; resolve taken 0x300 -> `o_data`={1,0x300}, `o_flush`=1. Push pc=0x104 predicted taken 0x180 is not-taken -> `o_data`={1,0x108}.
3. Push 4 entries (0x10, 0x20, 0x30, 0x40, all correctly predicted not-taken) -> `pred_ready`=0 and `o_count`=4. A 5th push is held off. Simultaneous push+correct resolve while full -> pop only; `o_count`=3, `o_data`={0,0x14}.
4. Push 3 entries, with push in the same cycle as a mispredict resolve of the head -> `o_count`=0 after the edge, the new push is dropped, and the next resolve pulses `o_underflow` with no `o_fire`.
5. Push pc=0xFFFFFFFC not-taken; resolve not-taken -> `o_data`={0,0x00000000} (wrap).
6. Assert rst low mid-stream with 2 entries held and a resolve pending -> outputs 0 immediately, `o_count`=0; after release the first push/resolve behaves as in scenario 1.

Source files
------------

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//
// This block holds the fetch unit's in-flight branch predictions in a small
// in-order queue. When execute reports a branch outcome, the block compares
// that outcome with the oldest prediction in the queue. One cycle later it
// emits a {mispredict, correct_pc} word to the branch-correction counter
// stage. On a mispredict, every younger prediction is flushed.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   pred_valid   fetch presents a prediction
//   pred_ready   queue can accept (not full, from registered count)
//   pred_pc      PC of the predicted branch
//   pred_taken   predicted direction
//   pred_target  predicted target (ignored when not taken)
//   res_valid    execute resolves the oldest outstanding branch
//   res_taken    actual direction
//   res_target   actual target
//   o_fire       one-cycle strobe, o_data valid
//   o_data       {mispredict, correct_pc}, held until the next o_fire
//   o_flush      one-cycle pulse alongside a mispredict o_fire
//   o_underflow  one-cycle pulse after a resolve with an empty queue
//   o_count      number of entries held
// ---------------------------------------------------------------------------
module branch_resolve #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pred_valid,
    output logic                   pred_ready,
    input  logic [PC_W-1:0]        pred_pc,
    input  logic                   pred_taken,
    input  logic [PC_W-1:0]        pred_target,
    input  logic                   res_valid,
    input  logic                   res_taken,
    input  logic [PC_W-1:0]        res_target,
    output logic                   o_fire,
    output logic [PC_W:0]          o_data,
    output logic                   o_flush,
    output logic                   o_underflow,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            empty;
    logic            do_push;
    logic            do_pop;
    logic            mispredict;
    logic [PC_W-1:0] correct_pc;

    assign empty      = (count == '0);
    assign pred_ready = (count != FULL_CNT);
    assign do_push    = pred_valid && pred_ready;
    assign do_pop     = res_valid && !empty;
    assign head       = mem[rd_ptr];
    assign o_count    = count;

    // The predicted target matters only when the branch was actually taken.
    // A direction mismatch already counts as a mispredict.
    always_comb begin
        mispredict = (res_taken != head.taken) ||
                     (res_taken && (res_target != head.target));
        correct_pc = res_taken ? res_target : head.pc + PC_W'(4);
    end

    // NOTE: queue storage has no reset. The count and pointers define which
    // entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= '{pc: pred_pc, taken: pred_taken, target: pred_target};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            o_fire      <= 1'b0;
            o_data      <= '0;
            o_flush     <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (do_pop && mispredict) begin
                // Flush: drop every entry, including any push in this cycle.
                // wr_ptr is left unchanged, so a same-cycle write is orphaned.
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(do_push) - CW'(do_pop);
            end

            o_fire      <= do_pop;
            o_flush     <= do_pop && mispredict;
            o_underflow <= res_valid && empty;
            if (do_pop) begin
                o_data <= {mispredict, correct_pc};
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve
//
// Self-checking bench for branch_resolve. A queue-based reference model
// predicts o_fire, o_data, o_flush, o_underflow, o_count and pred_ready for
// every cycle. Directed scenarios run first, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_branch_resolve;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } pred_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pred_valid = 1'b0;
    logic            pred_ready;
    logic [PC_W-1:0] pred_pc = '0;
    logic            pred_taken = 1'b0;
    logic [PC_W-1:0] pred_target = '0;
    logic            res_valid = 1'b0;
    logic            res_taken = 1'b0;
    logic [PC_W-1:0] res_target = '0;
    logic            o_fire;
    logic [PC_W:0]   o_data;
    logic            o_flush;
    logic            o_underflow;
    logic [2:0]      o_count;

    int n_cmp = 0;
    int n_err = 0;

    pred_t         q[$];
    logic [PC_W:0] exp_data = '0;

    branch_resolve #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_ready(pred_ready),
        .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .o_fire(o_fire), .o_data(o_data), .o_flush(o_flush),
        .o_underflow(o_underflow), .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus and advance the model. Then check every
    // output 1 ns after the edge.
    task automatic step(input logic pv, input logic [PC_W-1:0] pc, input logic pt,
                        input logic [PC_W-1:0] ptg, input logic rv, input logic rt,
                        input logic [PC_W-1:0] rtg, input string tag);
        logic            accept;
        logic            e_fire, e_flush, e_uf, mis;
        logic [PC_W-1:0] cpc;
        pred_t           h;
        pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_target = ptg;
        res_valid = rv; res_taken = rt; res_target = rtg;
        #1;
        check({tag, ".ready"}, 64'(pred_ready), 64'(q.size() < DEPTH));

        accept  = pv && (q.size() < DEPTH);
        e_fire  = 1'b0;
        e_flush = 1'b0;
        e_uf    = 1'b0;
        if (rv && q.size() > 0) begin
            h   = q.pop_front();
            mis = (rt != h.taken) || (rt && rtg != h.target);
            cpc = rt ? rtg : h.pc + 32'd4;
            e_fire   = 1'b1;
            e_flush  = mis;
            exp_data = {mis, cpc};
            if (mis) q.delete();
            else if (accept) q.push_back('{pc, pt, ptg});
        end else begin
            e_uf = rv;
            if (accept) q.push_back('{pc, pt, ptg});
        end

        @(posedge clk);
        #1;
        check({tag, ".fire"},  64'(o_fire),      64'(e_fire));
        check({tag, ".data"},  64'(o_data),      64'(exp_data));
        check({tag, ".flush"}, 64'(o_flush),     64'(e_flush));
        check({tag, ".uf"},    64'(o_underflow), 64'(e_uf));
        check({tag, ".count"}, 64'(o_count),     64'(q.size()));
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic push(input logic [PC_W-1:0] pc, input logic pt,
                        input logic [PC_W-1:0] ptg, input string tag);
        step(1'b1, pc, pt, ptg, 1'b0, 1'b0, '0, tag);
    endtask

    task automatic resolve(input logic rt, input logic [PC_W-1:0] rtg, input string tag);
        step(1'b0, '0, 1'b0, '0, 1'b1, rt, rtg, tag);
    endtask

    initial begin
        // Reset state.
        #3;
        check("rst.fire",  64'(o_fire),      64'(0));
        check("rst.data",  64'(o_data),      64'(0));
        check("rst.flush", 64'(o_flush),     64'(0));
        check("rst.uf",    64'(o_underflow), 64'(0));
        check("rst.count", 64'(o_count),     64'(0));
        #9 rst = 1'b1;
        #1 check("rst.ready", 64'(pred_ready), 64'(1));

        // Scenario 1: taken branch, correctly predicted.
        push(32'h100, 1'b1, 32'h200, "s1.push");
        resolve(1'b1, 32'h200, "s1.res");
        check("s1.word", 64'(o_data), 64'({1'b0, 32'h200}));

        // Scenario 2: two mispredicts.
        push(32'h100, 1'b0, 32'h0, "s2a.push");
        resolve(1'b1, 32'h300, "s2a.res");
        check("s2a.word", 64'(o_data), 64'({1'b1, 32'h300}));
        push(32'h104, 1'b1, 32'h180, "s2b.push");
        resolve(1'b0, 32'h0, "s2b.res");
        check("s2b.word", 64'(o_data), 64'({1'b1, 32'h108}));

        // Scenario 3: fill the queue, hold off a 5th push, then push and pop
        // in the same cycle while full.
        for (int i = 1; i <= 4; i++) push(32'(i * 16), 1'b0, 32'h0, "s3.fill");
        check("s3.full", 64'(pred_ready), 64'(0));
        push(32'h50, 1'b0, 32'h0, "s3.held");
        step(1'b1, 32'h60, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, "s3.pushpop");
        check("s3.word", 64'(o_data), 64'({1'b0, 32'h14}));
        while (q.size() > 0) resolve(1'b0, 32'h0, "s3.drain");

        // Scenario 4: a push in the same cycle as a mispredict is dropped.
        for (int i = 0; i < 3; i++) push(32'h400 + 32'(i * 4), 1'b0, 32'h0, "s4.fill");
        step(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b1, 32'h800, "s4.flush");
        resolve(1'b0, 32'h0, "s4.under");

        // Scenario 5: PC wrap on a not-taken branch.
        push(32'hFFFF_FFFC, 1'b0, 32'h0, "s5.push");
        resolve(1'b0, 32'h0, "s5.res");
        check("s5.word", 64'(o_data), 64'({1'b0, 32'h0}));

        // Scenario 6: asynchronous reset with entries held and o_fire high.
        for (int i = 0; i < 3; i++) push(32'h600 + 32'(i * 4), 1'b0, 32'h0, "s6.fill");
        resolve(1'b0, 32'h0, "s6.res");
        res_valid = 1'b1;
        #3 rst = 1'b0;
        #1;
        check("s6.fire",  64'(o_fire),      64'(0));
        check("s6.data",  64'(o_data),      64'(0));
        check("s6.flush", 64'(o_flush),     64'(0));
        check("s6.count", 64'(o_count),     64'(0));
        res_valid = 1'b0;
        q.delete();
        exp_data = '0;
        #2 rst = 1'b1;
        push(32'h100, 1'b1, 32'h200, "s6.push");
        resolve(1'b1, 32'h200, "s6.again");
        check("s6.word", 64'(o_data), 64'({1'b0, 32'h200}));

        // Randomized traffic. Targets come from a small pool, so correct
        // predictions are common.
        for (int i = 0; i < 400; i++) begin
            logic [PC_W-1:0] tgt_pool [4];
            tgt_pool = '{32'h1000, 32'h2000, 32'h3000, 32'hFFFF_FFFC};
            step(($urandom_range(0, 9) < 6), {$urandom_range(0, 255), 2'b00} + 32'hFFFF_FC00,
                 1'($urandom), tgt_pool[$urandom_range(0, 3)],
                 ($urandom_range(0, 9) < 4), 1'($urandom), tgt_pool[$urandom_range(0, 3)],
                 "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
